// File: rtl/ip_pkg.sv
// Shared IPv4 definitions for the IP transmit/receive path: protocol numbers,
// header constants, transmitter FSM states and a header byte selector.
package ip_pkg;

  localparam logic [7:0]  IP_PROTO_ICMP      = 8'h01;
  localparam logic [7:0]  IP_PROTO_TCP       = 8'h06;
  localparam logic [7:0]  IP_PROTO_UDP       = 8'h11;

  localparam logic [3:0]  IPV4_VERSION       = 4'd4;
  localparam logic [3:0]  IPV4_IHL           = 4'd5;
  localparam logic [15:0] IPV4_HDR_LEN       = 16'd20;
  localparam logic [15:0] IPV4_MAX_PAYLOAD   = 16'd65515;
  localparam logic [3:0]  IPV4_CSUM_WORDS    = 4'd9;
  localparam logic [4:0]  IPV4_HDR_LAST_BYTE = 5'd19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECKSUM,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DISCARD
  } ipTxState_t;

  // Byte idx of a 160-bit header held MSB first (byte 0 = version/IHL).
  function automatic logic [7:0] headerByte(input logic [159:0] hdr, input logic [4:0] idx);
    logic [159:0] shifted;
    shifted = hdr << {idx, 3'b000};
    return shifted[159:152];
  endfunction

endpackage

// File: rtl/ip_checksum_accumulator.sv
// One's-complement header checksum: sums 16-bit words into a 20-bit accumulator
// and presents the twice-folded, inverted result. Shared with the receive path.
module ip_checksum_accumulator
  import ip_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [15:0] i_word,
  output logic [15:0] o_checksum
);

  logic [19:0] r_acc;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_acc <= '0;
    end else if (i_valid) begin
      r_acc <= r_acc + {4'h0, i_word};
    end
  end

  // Two end-around-carry folds cover any sum of up to sixteen words.
  assign w_fold1    = {1'b0, r_acc[15:0]} + {13'h0000, r_acc[19:16]};
  assign w_fold2    = w_fold1[15:0] + {15'h0000, w_fold1[16]};
  assign o_checksum = ~w_fold2;

endmodule

// File: rtl/ip_datagram_transmitter.sv
// IPv4 datagram transmitter: prepends a 20-byte header to a pass-through payload
// stream. Define IP_TX_STATS_EN to add frames_sent / frames_dropped counters.
module ip_datagram_transmitter
  import ip_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] DEFAULT_TTL   = 8'd64,
  parameter logic       DONT_FRAGMENT = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pl_tx_tvalid,
  output logic                  pl_tx_tready,
  input  logic [DATA_WIDTH-1:0] pl_tx_tdata,
  input  logic                  pl_tx_tlast,
  input  logic [7:0]            pl_protocol,
  input  logic [15:0]           pl_length,
  input  logic [31:0]           pl_dest_ip,
  input  logic [31:0]           local_ip_address,
  output logic                  eth_tx_tvalid,
  input  logic                  eth_tx_tready,
  output logic [DATA_WIDTH-1:0] eth_tx_tdata,
  output logic                  eth_tx_tlast,
  output logic                  length_error
`ifdef IP_TX_STATS_EN
  ,
  output logic [15:0]           frames_sent,
  output logic [15:0]           frames_dropped
`endif
);

  ipTxState_t  r_state;
  ipTxState_t  w_nextState;

  logic [7:0]  r_protocol;
  logic [15:0] r_length;
  logic [31:0] r_destIp;
  logic [31:0] r_srcIp;
  logic [15:0] r_id;
  logic [3:0]  r_wordIdx;
  logic [4:0]  r_byteIdx;
  logic [15:0] r_count;
  logic [15:0] r_checksum;
  logic        r_lengthError;

  logic        w_lenBad;
  logic        w_lastByCount;
  logic        w_lengthErrorNext;
  logic [15:0] w_totalLen;
  logic [15:0] w_flagsWord;
  logic [159:0] w_header;
  logic [7:0]  w_headerByte;
  logic        w_accClear;
  logic        w_accValid;
  logic [15:0] w_accWord;
  logic [15:0] w_accResult;

  assign w_lenBad      = (pl_length == 16'd0) || (pl_length > IPV4_MAX_PAYLOAD);
  assign w_lastByCount = (r_count == r_length - 16'd1);
  assign w_totalLen    = IPV4_HDR_LEN + r_length;
  assign w_flagsWord   = {1'b0, DONT_FRAGMENT, 1'b0, 13'h0000};
  assign w_header      = {IPV4_VERSION, IPV4_IHL, 8'h00, w_totalLen, r_id, w_flagsWord,
                          DEFAULT_TTL, r_protocol, r_checksum, r_srcIp, r_destIp};
  assign w_headerByte  = headerByte(w_header, r_byteIdx);
  assign length_error  = r_lengthError;

  // Header words in the order the checksum accumulator consumes them.
  always_comb begin
    case (r_wordIdx)
      4'd0:    w_accWord = {IPV4_VERSION, IPV4_IHL, 8'h00};
      4'd1:    w_accWord = w_totalLen;
      4'd2:    w_accWord = r_id;
      4'd3:    w_accWord = w_flagsWord;
      4'd4:    w_accWord = {DEFAULT_TTL, r_protocol};
      4'd5:    w_accWord = r_srcIp[31:16];
      4'd6:    w_accWord = r_srcIp[15:0];
      4'd7:    w_accWord = r_destIp[31:16];
      4'd8:    w_accWord = r_destIp[15:0];
      default: w_accWord = 16'h0000;
    endcase
  end

  assign w_accClear = (r_state == ST_IDLE);
  assign w_accValid = (r_state == ST_CHECKSUM) && (r_wordIdx < IPV4_CSUM_WORDS);

  ip_checksum_accumulator u_checksum (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_accClear),
    .i_valid    (w_accValid),
    .i_word     (w_accWord),
    .o_checksum (w_accResult)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState       = r_state;
    pl_tx_tready      = 1'b0;
    eth_tx_tvalid     = 1'b0;
    eth_tx_tdata      = '0;
    eth_tx_tlast      = 1'b0;
    w_lengthErrorNext = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pl_tx_tvalid) begin
          if (w_lenBad) begin
            w_nextState       = ST_DISCARD;
            w_lengthErrorNext = 1'b1;
          end else begin
            w_nextState = ST_CHECKSUM;
          end
        end
      end
      ST_CHECKSUM: begin
        if (r_wordIdx == IPV4_CSUM_WORDS) begin
          w_nextState = ST_HEADER;
        end
      end
      ST_HEADER: begin
        eth_tx_tvalid = 1'b1;
        eth_tx_tdata  = w_headerByte;
        if (eth_tx_tready && (r_byteIdx == IPV4_HDR_LAST_BYTE)) begin
          w_nextState = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        eth_tx_tvalid = pl_tx_tvalid;
        pl_tx_tready  = eth_tx_tready;
        eth_tx_tdata  = pl_tx_tdata;
        eth_tx_tlast  = pl_tx_tlast || w_lastByCount;
        // Payload runs over its declared length: end the datagram, drop the rest.
        if (pl_tx_tvalid && eth_tx_tready) begin
          if (w_lastByCount && !pl_tx_tlast) begin
            w_nextState       = ST_DISCARD;
            w_lengthErrorNext = 1'b1;
          end else if (pl_tx_tlast) begin
            w_nextState       = ST_IDLE;
            w_lengthErrorNext = !w_lastByCount;
          end
        end
      end
      ST_DISCARD: begin
        pl_tx_tready = 1'b1;
        if (pl_tx_tvalid && pl_tx_tlast) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Sideband latch, header sequencing, identification and payload counting.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_protocol    <= '0;
      r_length      <= '0;
      r_destIp      <= '0;
      r_srcIp       <= '0;
      r_id          <= '0;
      r_wordIdx     <= '0;
      r_byteIdx     <= '0;
      r_count       <= '0;
      r_checksum    <= '0;
      r_lengthError <= 1'b0;
    end else begin
      r_lengthError <= w_lengthErrorNext;
      case (r_state)
        ST_IDLE: begin
          if (pl_tx_tvalid) begin
            r_protocol <= pl_protocol;
            r_length   <= pl_length;
            r_destIp   <= pl_dest_ip;
            r_srcIp    <= local_ip_address;
            r_wordIdx  <= '0;
          end
        end
        ST_CHECKSUM: begin
          r_wordIdx <= r_wordIdx + 4'd1;
          if (r_wordIdx == IPV4_CSUM_WORDS) begin
            r_checksum <= w_accResult;
            r_byteIdx  <= '0;
          end
        end
        ST_HEADER: begin
          if (eth_tx_tready) begin
            r_byteIdx <= r_byteIdx + 5'd1;
            if (r_byteIdx == IPV4_HDR_LAST_BYTE) begin
              r_id    <= r_id + 16'd1;
              r_count <= '0;
            end
          end
        end
        ST_PAYLOAD: begin
          if (pl_tx_tvalid && eth_tx_tready) begin
            r_count <= r_count + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IP_TX_STATS_EN
  logic [15:0] r_framesSent;
  logic [15:0] r_framesDropped;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_framesSent    <= '0;
      r_framesDropped <= '0;
    end else begin
      if (eth_tx_tvalid && eth_tx_tready && eth_tx_tlast) begin
        r_framesSent <= r_framesSent + 16'd1;
      end
      if ((r_state == ST_IDLE) && (w_nextState == ST_DISCARD)) begin
        r_framesDropped <= r_framesDropped + 16'd1;
      end
    end
  end

  assign frames_sent    = r_framesSent;
  assign frames_dropped = r_framesDropped;
`endif

endmodule

// File: tb/tb_ip_datagram_transmitter.sv
// Directed self-checking bench for ip_datagram_transmitter: header bytes,
// latency, length errors, discards, mid-frame reset and random downstream stalls.
module tb_ip_datagram_transmitter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pl_tx_tvalid;
  logic        pl_tx_tready;
  logic [7:0]  pl_tx_tdata;
  logic        pl_tx_tlast;
  logic [7:0]  pl_protocol;
  logic [15:0] pl_length;
  logic [31:0] pl_dest_ip;
  logic [31:0] local_ip_address;
  logic        eth_tx_tvalid;
  logic        eth_tx_tready;
  logic [7:0]  eth_tx_tdata;
  logic        eth_tx_tlast;
  logic        length_error;
`ifdef IP_TX_STATS_EN
  logic [15:0] framesSent;
  logic [15:0] framesDropped;
`endif

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  logic [7:0] obsQ[$];
  logic       obsLast[$];
  logic [7:0] expQ[$];
  logic       expLast[$];
  int         lerrCount;
  int         firstValidCycle;
  bit         seenValid;

  ip_datagram_transmitter dut (
    .clock            (clock),
    .reset            (reset),
    .pl_tx_tvalid     (pl_tx_tvalid),
    .pl_tx_tready     (pl_tx_tready),
    .pl_tx_tdata      (pl_tx_tdata),
    .pl_tx_tlast      (pl_tx_tlast),
    .pl_protocol      (pl_protocol),
    .pl_length        (pl_length),
    .pl_dest_ip       (pl_dest_ip),
    .local_ip_address (local_ip_address),
    .eth_tx_tvalid    (eth_tx_tvalid),
    .eth_tx_tready    (eth_tx_tready),
    .eth_tx_tdata     (eth_tx_tdata),
    .eth_tx_tlast     (eth_tx_tlast),
    .length_error     (length_error)
`ifdef IP_TX_STATS_EN
    ,
    .frames_sent      (framesSent),
    .frames_dropped   (framesDropped)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount++;

  // Records every downstream transfer; inputs only change just after posedge.
  always @(negedge clock) begin
    if (!reset) begin
      if (eth_tx_tvalid && eth_tx_tready) begin
        obsQ.push_back(eth_tx_tdata);
        obsLast.push_back(eth_tx_tlast);
      end
      if (eth_tx_tvalid && !seenValid) begin
        seenValid       = 1'b1;
        firstValidCycle = cycleCount;
      end
      if (length_error) lerrCount++;
    end
  end

  function automatic logic [7:0] payloadByte(input logic [7:0] seed, input int k);
    return seed + 8'(k * 7);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearObs();
    obsQ.delete();
    obsLast.delete();
    expQ.delete();
    expLast.delete();
    lerrCount = 0;
    seenValid = 1'b0;
  endtask

  task automatic expHeader(input logic [159:0] hdr);
    for (int i = 0; i < 20; i++) begin
      expQ.push_back(hdr[159 - 8*i -: 8]);
      expLast.push_back(1'b0);
    end
  endtask

  // Reference IPv4 header with a straightforward one's-complement checksum.
  task automatic expModelHeader(input logic [15:0] len, input logic [15:0] id, input logic [7:0] proto,
                                input logic [31:0] src, input logic [31:0] dst);
    logic [15:0]  total;
    logic [31:0]  sum;
    logic [159:0] hdr;
    total = len + 16'd20;
    sum = 32'h4500 + 32'(total) + 32'(id) + 32'h4000 + 32'({8'd64, proto})
        + 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]);
    while (sum[31:16] != 16'h0000) sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    hdr = {16'h4500, total, id, 16'h4000, 8'd64, proto, ~sum[15:0], src, dst};
    expHeader(hdr);
  endtask

  task automatic expPayload(input logic [7:0] seed, input int n, input bit lastOnFinal);
    for (int i = 0; i < n; i++) begin
      expQ.push_back(payloadByte(seed, i));
      expLast.push_back(lastOnFinal && (i == n - 1));
    end
  endtask

  // Drives one upstream frame; abortAt >= 0 returns with byte abortAt presented.
  task automatic applyStimulus(input logic [7:0] proto, input logic [15:0] len, input logic [31:0] src,
                               input logic [31:0] dst, input int nBytes, input logic [7:0] seed,
                               input bit randomReady, input int abortAt, input string tag);
    int k;
    int cyc;
    bit fire;
    k   = 0;
    cyc = 0;
    pl_protocol      = proto;
    pl_length        = len;
    local_ip_address = src;
    pl_dest_ip       = dst;
    pl_tx_tvalid     = 1'b1;
    pl_tx_tdata      = payloadByte(seed, 0);
    pl_tx_tlast      = (nBytes == 1);
    while ((k < nBytes) && (k != abortAt) && (cyc < 2000)) begin
      @(negedge clock);
      fire = pl_tx_tready;
      @(posedge clock);
      #1;
      cyc++;
      if (randomReady) eth_tx_tready = ($urandom_range(0, 1) == 1);
      if (fire) begin
        k++;
        pl_tx_tdata = payloadByte(seed, k);
        pl_tx_tlast = (k == nBytes - 1);
        if (k == nBytes) begin
          pl_tx_tvalid = 1'b0;
          pl_tx_tlast  = 1'b0;
        end
      end
    end
    if (abortAt < 0) checkOutput({tag, "_src_done"}, 32'(k), 32'(nBytes));
  endtask

  task automatic settle(input int n);
    eth_tx_tready = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic compareFrame(input string tag, input int expLerr);
    int bad;
    bad = 0;
    checkOutput({tag, "_count"}, 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; (i < expQ.size()) && (i < obsQ.size()); i++) begin
      if ((obsQ[i] !== expQ[i]) || (obsLast[i] !== expLast[i])) bad++;
    end
    checkOutput({tag, "_bytes"}, 32'(bad), 32'd0);
    checkOutput({tag, "_lerr"}, 32'(lerrCount), 32'(expLerr));
  endtask

  initial begin
    int startCycle;
    logic [31:0] idObs;

    reset            = 1'b1;
    pl_tx_tvalid     = 1'b0;
    pl_tx_tdata      = '0;
    pl_tx_tlast      = 1'b0;
    pl_protocol      = '0;
    pl_length        = '0;
    pl_dest_ip       = '0;
    local_ip_address = '0;
    eth_tx_tready    = 1'b1;
    lerrCount        = 0;
    seenValid        = 1'b0;
    firstValidCycle  = 0;

    $display("[TB] reset state");
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_eth_tvalid", 32'(eth_tx_tvalid), 32'd0);
    checkOutput("rst_pl_tready", 32'(pl_tx_tready), 32'd0);
    checkOutput("rst_eth_tlast", 32'(eth_tx_tlast), 32'd0);
    checkOutput("rst_eth_tdata", 32'(eth_tx_tdata), 32'd0);
    checkOutput("rst_length_error", 32'(length_error), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] frame A: UDP 95 bytes, first after reset");
    clearObs();
    expHeader(160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7);
    expPayload(8'h10, 95, 1'b1);
    startCycle = cycleCount;
    applyStimulus(8'h11, 16'd95, 32'hC0A8_0001, 32'hC0A8_00C7, 95, 8'h10, 1'b0, -1, "A");
    settle(4);
    checkOutput("A_latency", 32'(firstValidCycle - (startCycle + 1)), 32'd10);
    compareFrame("A", 0);

    $display("[TB] frame B: length 10, tlast on byte 6");
    clearObs();
    expModelHeader(16'd10, 16'd1, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7);
    expPayload(8'h33, 6, 1'b1);
    applyStimulus(8'h11, 16'd10, 32'hC0A8_0001, 32'hC0A8_00C7, 6, 8'h33, 1'b0, -1, "B");
    settle(4);
    idObs = (obsQ.size() >= 6) ? {16'h0000, obsQ[4], obsQ[5]} : 32'hFFFF_FFFF;
    checkOutput("B_id", idObs, 32'd1);
    compareFrame("B", 1);

    $display("[TB] frame C: length 4, tlast on byte 8");
    clearObs();
    expModelHeader(16'd4, 16'd2, 8'h06, 32'h0A00_0001, 32'h0A00_0102);
    expPayload(8'h5A, 4, 1'b1);
    applyStimulus(8'h06, 16'd4, 32'h0A00_0001, 32'h0A00_0102, 8, 8'h5A, 1'b0, -1, "C");
    settle(4);
    compareFrame("C", 1);

    $display("[TB] rejected lengths 0 and 65516");
    clearObs();
    applyStimulus(8'h11, 16'd0, 32'h0A00_0001, 32'h0A00_0102, 3, 8'h01, 1'b0, -1, "D0");
    settle(4);
    compareFrame("D0", 1);
    clearObs();
    applyStimulus(8'h11, 16'd65516, 32'h0A00_0001, 32'h0A00_0102, 2, 8'h02, 1'b0, -1, "D1");
    settle(4);
    compareFrame("D1", 1);

    $display("[TB] frame E: clean frame after rejects keeps id sequence");
    clearObs();
    expModelHeader(16'd8, 16'd3, 8'h11, 32'hAC10_0005, 32'hAC10_FFFE);
    expPayload(8'hE0, 8, 1'b1);
    applyStimulus(8'h11, 16'd8, 32'hAC10_0005, 32'hAC10_FFFE, 8, 8'hE0, 1'b0, -1, "E");
    settle(4);
    compareFrame("E", 0);

    $display("[TB] frame R: reset during payload byte 3");
    clearObs();
    expModelHeader(16'd20, 16'd4, 8'h06, 32'hAC10_0005, 32'hAC10_FFFE);
    expPayload(8'h70, 2, 1'b0);
    applyStimulus(8'h06, 16'd20, 32'hAC10_0005, 32'hAC10_FFFE, 20, 8'h70, 1'b0, 2, "R");
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("R_eth_tvalid", 32'(eth_tx_tvalid), 32'd0);
    checkOutput("R_pl_tready", 32'(pl_tx_tready), 32'd0);
    checkOutput("R_eth_tlast", 32'(eth_tx_tlast), 32'd0);
    checkOutput("R_eth_tdata", 32'(eth_tx_tdata), 32'd0);
    compareFrame("R", 0);
    @(posedge clock);
    #1;
    pl_tx_tvalid = 1'b0;
    pl_tx_tlast  = 1'b0;
    reset        = 1'b0;
    settle(2);

    $display("[TB] frames F: back-to-back ICMP with random downstream stalls");
    clearObs();
    expModelHeader(16'd4, 16'd0, 8'h01, 32'h0102_0304, 32'hFEDC_BA98);
    expPayload(8'hA1, 4, 1'b1);
    expModelHeader(16'd4, 16'd1, 8'h01, 32'h0102_0304, 32'hFEDC_BA98);
    expPayload(8'hC3, 4, 1'b1);
    applyStimulus(8'h01, 16'd4, 32'h0102_0304, 32'hFEDC_BA98, 4, 8'hA1, 1'b1, -1, "F1");
    applyStimulus(8'h01, 16'd4, 32'h0102_0304, 32'hFEDC_BA98, 4, 8'hC3, 1'b1, -1, "F2");
    settle(4);
    compareFrame("F", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
